// File: rtl/duty_slew.sv
// Duty-command conditioning: clamps accepted targets and slews duty on PWM period start.
// Optional macro DUTY_SLEW_EN: when defined duty moves at most STEP per period, else it jumps to target.
module duty_slew #(
  parameter logic [11:0] STEP     = 12'h040,
  parameter logic [11:0] DUTY_MIN = 12'h030,
  parameter logic [11:0] DUTY_MAX = 12'hFC0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] tgt,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  input  logic        prd_strt,
  input  logic        flt,
  input  logic        flt_clr,
  output logic [11:0] duty,
  output logic        at_tgt,
  output logic        in_flt
);

  typedef enum logic [1:0] {IDLE, RAMP, FAULT} state_t;

`ifdef DUTY_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif
  // Without slewing the limit exceeds any possible |diff|, so a step always lands on target.
  localparam logic [12:0] LIMIT = SLEW ? {1'b0, STEP} : 13'h1000;

  state_t             state;
  logic [11:0]        tgt_q;
  logic [11:0]        tgt_clamped;
  logic [11:0]        tgt_nxt;
  logic [11:0]        stepped;
  logic [11:0]        duty_nxt;
  logic signed [12:0] diff;
  logic signed [12:0] mag;
  logic               accept;
  logic               lands;

  assign accept = tgt_vld & tgt_rdy;

  always_comb begin
    tgt_clamped = tgt;
    if (tgt == 12'h000)
      tgt_clamped = 12'h000;
    else if (tgt < DUTY_MIN)
      tgt_clamped = DUTY_MIN;
    else if (tgt > DUTY_MAX)
      tgt_clamped = DUTY_MAX;
  end

  always_comb begin
    diff    = $signed({1'b0, tgt_q}) - $signed({1'b0, duty});
    mag     = diff[12] ? -diff : diff;
    stepped = tgt_q;
    if ($unsigned(mag) > LIMIT)
      stepped = diff[12] ? (duty - STEP) : (duty + STEP);
  end

  // A step triggered together with an accept uses the old target register.
  always_comb begin
    duty_nxt = prd_strt ? stepped : duty;
    tgt_nxt  = accept ? tgt_clamped : tgt_q;
    lands    = (duty_nxt == tgt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tgt_q   <= 12'h000;
      duty    <= 12'h000;
      at_tgt  <= 1'b1;
      in_flt  <= 1'b0;
      tgt_rdy <= 1'b1;
    end else if (flt) begin
      state   <= FAULT;
      duty    <= 12'h000;
      at_tgt  <= 1'b0;
      in_flt  <= 1'b1;
      tgt_rdy <= 1'b0;
    end else if (state == FAULT) begin
      if (flt_clr) begin
        state   <= IDLE;
        tgt_q   <= 12'h000;
        duty    <= 12'h000;
        at_tgt  <= 1'b1;
        in_flt  <= 1'b0;
        tgt_rdy <= 1'b1;
      end
    end else begin
      tgt_q   <= tgt_nxt;
      duty    <= duty_nxt;
      at_tgt  <= lands;
      in_flt  <= 1'b0;
      tgt_rdy <= 1'b1;
      state   <= lands ? IDLE : RAMP;
    end
  end

endmodule

// File: tb/tb_duty_slew.sv
// Scoreboard bench for duty_slew: driver pushes model predictions, monitor compares each cycle.
module tb_duty_slew;

  localparam int STEP = 64;
  localparam int DMIN = 48;
  localparam int DMAX = 4032;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] tgt = 12'h000;
  logic        tgt_vld = 1'b0;
  logic        tgt_rdy;
  logic        prd_strt = 1'b0;
  logic        flt = 1'b0;
  logic        flt_clr = 1'b0;
  logic [11:0] duty;
  logic        at_tgt;
  logic        in_flt;

  duty_slew dut (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_vld(tgt_vld), .tgt_rdy(tgt_rdy),
    .prd_strt(prd_strt), .flt(flt), .flt_clr(flt_clr),
    .duty(duty), .at_tgt(at_tgt), .in_flt(in_flt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] duty;
    logic        at_tgt;
    logic        in_flt;
    logic        tgt_rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  // Reference model: the commanded target, the duty presently applied, and a fault latch.
  int m_tgt = 0;
  int m_duty = 0;
  bit m_flt = 0;

  function automatic int clampv(input int v);
    if (v == 0) return 0;
    if (v < DMIN) return DMIN;
    if (v > DMAX) return DMAX;
    return v;
  endfunction

  function automatic int stepf(input int d, input int t);
`ifdef DUTY_SLEW_EN
    int delta;
    delta = t - d;
    if (delta <= STEP && delta >= -STEP) return t;
    return (delta > 0) ? d + STEP : d - STEP;
`else
    return t + 0 * d;
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.duty    = 12'(m_duty);
    e.at_tgt  = !m_flt && (m_duty == m_tgt);
    e.in_flt  = m_flt;
    e.tgt_rdy = !m_flt;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got duty=%h at_tgt=%b in_flt=%b rdy=%b, need duty=%h at_tgt=%b in_flt=%b rdy=%b",
               name, act.duty, act.at_tgt, act.in_flt, act.tgt_rdy,
               req.duty, req.at_tgt, req.in_flt, req.tgt_rdy);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the coming edge.
  task automatic cyc(input int t, input bit v, input bit p, input bit f, input bit c);
    int nd;
    @(negedge clk);
    tgt = 12'(t); tgt_vld = v; prd_strt = p; flt = f; flt_clr = c;
    if (f) begin
      m_flt = 1; m_duty = 0;
    end else if (m_flt) begin
      if (c) begin
        m_flt = 0; m_tgt = 0; m_duty = 0;
      end
    end else begin
      nd = p ? stepf(m_duty, m_tgt) : m_duty;
      if (v) m_tgt = clampv(t);
      m_duty = nd;
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic async_reset();
    exp_t act, req;
    @(negedge clk);
    tgt_vld = 0; prd_strt = 0; flt = 0; flt_clr = 0;
    rst_n = 1'b0;
    #1;
    act = '{duty, at_tgt, in_flt, tgt_rdy};
    req = '{12'h000, 1'b1, 1'b0, 1'b1};
    check("async_reset", act, req);
    @(negedge clk);
    rst_n = 1'b1;
    m_tgt = 0; m_duty = 0; m_flt = 0;
  endtask

  always @(posedge clk) begin
    exp_t act, req;
    cyc_no++;
    #1;
    if (exp_q.size() > 0) begin
      req = exp_q.pop_front();
      act = '{duty, at_tgt, in_flt, tgt_rdy};
      check($sformatf("cycle%0d", cyc_no), act, req);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, need finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t;
    repeat (3) @(posedge clk);
    async_reset();
    idle(2);

    cyc(12'h100, 1, 0, 0, 0);
    pulses(4);
    idle(1);
    cyc(12'h0F0, 1, 0, 0, 0);
    pulses(1);
    cyc(12'h100, 1, 0, 0, 0);
    pulses(1);
    cyc(12'h200, 1, 1, 0, 0);
    idle(1);
    pulses(1);
    idle(1);

    cyc(12'hFFF, 1, 0, 0, 0);
    pulses(70);
    cyc(12'h010, 1, 0, 0, 0);
    pulses(70);
    cyc(12'h000, 1, 0, 0, 0);
    pulses(3);

    cyc(12'h100, 1, 0, 0, 0);
    pulses(2);
    cyc(0, 0, 0, 1, 0);
    cyc(12'h300, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(12'h300, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    idle(1);
    pulses(2);

    cyc(12'hFC0, 1, 0, 0, 0);
    pulses(3);
    async_reset();
    idle(1);
    cyc(12'h800, 1, 0, 0, 0);
    pulses(1);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: t = 0;
        1: t = $urandom_range(1, 60);
        2: t = $urandom_range(4000, 4095);
        default: t = $urandom_range(0, 4095);
      endcase
      cyc(t, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 6) == 0));
    end
    idle(1);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
